// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the 4x4 keypad reader: debounce
//               FSM states, key-code constants, key actions and the
//               {row,col} code to hex-nibble map.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIGIT  = 2'd0,
        CLEAR  = 2'd1,
        COMMIT = 2'd2
    } action_t;

    // Key codes are {row[1:0], col[1:0]}
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_HASH = 4'hE;

    // Hex value printed on the key at a given {row,col} position
    function automatic logic [3:0] code_to_nibble(input logic [3:0] code);
        logic [3:0] nib;
        case (code)
            4'h0:    nib = 4'h1;
            4'h1:    nib = 4'h2;
            4'h2:    nib = 4'h3;
            4'h3:    nib = 4'hA;
            4'h4:    nib = 4'h4;
            4'h5:    nib = 4'h5;
            4'h6:    nib = 4'h6;
            4'h7:    nib = 4'hB;
            4'h8:    nib = 4'h7;
            4'h9:    nib = 4'h8;
            4'hA:    nib = 4'h9;
            4'hB:    nib = 4'hC;
            4'hD:    nib = 4'h0;
            4'hF:    nib = 4'hD;
            default: nib = 4'h0;    // '*' and '#' carry no digit
        endcase
        return nib;
    endfunction

    // What an accepted key does to the entry/IO registers
    function automatic action_t code_to_action(input logic [3:0] code);
        action_t act;
        if (code == KEY_STAR) begin
            act = CLEAR;
        end else if (code == KEY_HASH) begin
            act = COMMIT;
        end else begin
            act = DIGIT;
        end
        return act;
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_if
// Description : Keypad pins, CPU IO read port and display echo of the keypad
//               reader. The overrun flag exists only when KEYPAD_OVERRUN_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_if;

    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        IORead_signal;
    logic [15:0] io_read_data;
    logic        data_valid;
    logic [15:0] entry_data;
    logic        key_pressed;
`ifdef KEYPAD_OVERRUN_EN
    logic        overrun;
`endif

    // Environment side: keypad matrix and CPU
    modport master (
        output row_in,
        output IORead_signal,
        input  col_out,
        input  io_read_data,
        input  data_valid,
        input  entry_data,
`ifdef KEYPAD_OVERRUN_EN
        input  overrun,
`endif
        input  key_pressed
    );

    // Keypad reader side
    modport slave (
        input  row_in,
        input  IORead_signal,
        output col_out,
        output io_read_data,
        output data_valid,
        output entry_data,
`ifdef KEYPAD_OVERRUN_EN
        output overrun,
`endif
        output key_pressed
    );

endinterface : keypad_if
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : Column scanner for a 4x4 keypad. Drives one column low for
//               SCAN_DIV cycles at a time, synchronises the rows through two
//               flops, samples them in the last dwell cycle and, after column
//               3, reports a full-scan result: single hit with its {row,col}
//               code, or no hit (zero or multiple keys down).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  wire logic       clk,
    input  wire logic       rst,          // asynchronous, active-low
    input  wire logic [3:0] i_row,
    output logic      [3:0] o_col,
    output logic            o_scan_done,
    output logic            o_hit,
    output logic      [3:0] o_code
);

    localparam int               c_DW         = $clog2(SCAN_DIV);
    localparam logic [c_DW-1:0]  c_DWELL_LAST = c_DW'(SCAN_DIV - 1);
    localparam logic [c_DW-1:0]  c_DWELL_ONE  = c_DW'(1);

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [c_DW-1:0] r_dwell;
    logic [1:0]      r_col;
    logic [15:0]     r_acc;       // one bit per key, 1 = pressed, index {row,col}
    logic            r_done;
    logic            r_hit;
    logic [3:0]      r_code;

    logic            w_last;
    logic [15:0]     w_acc_next;
    logic [4:0]      w_nhit;
    logic [3:0]      w_first;

    assign w_last = (r_dwell == c_DWELL_LAST);

    // Merge the rows seen on the current column into the key map and count hits
    always_comb begin
        w_acc_next = r_acc;
        w_nhit     = 5'd0;
        w_first    = 4'd0;
        for (int r = 0; r < 4; r++) begin
            w_acc_next[{r[1:0], r_col}] = ~r_sync2[r];
        end
        for (int i = 0; i < 16; i++) begin
            if (w_acc_next[i]) begin
                w_nhit  = w_nhit + 5'd1;
                w_first = 4'(i);
            end
        end
    end

    // Synchroniser, dwell/column counters and end-of-scan result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
            r_dwell <= '0;
            r_col   <= 2'd0;
            r_acc   <= 16'd0;
            r_done  <= 1'b0;
            r_hit   <= 1'b0;
            r_code  <= 4'd0;
        end else begin
            r_sync1 <= i_row;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            if (w_last) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_acc   <= w_acc_next;
                if (r_col == 2'd3) begin
                    r_done <= 1'b1;
                    // More than one key down is ghost-prone, so it reads as none
                    r_hit  <= (w_nhit == 5'd1);
                    r_code <= (w_nhit == 5'd1) ? w_first : 4'd0;
                end
            end else begin
                r_dwell <= r_dwell + c_DWELL_ONE;
            end
        end
    end

    assign o_col       = ~(4'b0001 << r_col);
    assign o_scan_done = r_done;
    assign o_hit       = r_hit;
    assign o_code      = r_code;

endmodule : keypad_scan
`default_nettype wire

// File: rtl/keypad_reader.sv
`default_nettype none
// ============================================================================
// Module      : keypad_reader
// Description : 4x4 keypad input block. Debounces full-scan results, shifts
//               hex digits into a 16-bit entry, '*' clears it and '#' commits
//               it to a CPU-readable IO word with a valid flag.
//               Optional macro KEYPAD_OVERRUN_EN adds a sticky overrun flag
//               for commits that land on an unread word.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_reader
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  wire logic clk,
    input  wire logic rst,               // asynchronous, active-low
    keypad_if.slave   bus
);

    localparam int              c_CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_CW-1:0] c_DB  = c_CW'(DEBOUNCE_SCANS);
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    logic        w_scan_done;
    logic        w_hit;
    logic [3:0]  w_code;
    logic [3:0]  w_col;

    state_t          r_state, w_state_nx;
    logic [c_CW-1:0] r_cnt,   w_cnt_nx;
    logic [c_CW-1:0] r_rel,   w_rel_nx;
    logic [3:0]      r_code,  w_code_nx;
    logic            w_fire;

    logic [15:0] r_entry;
    logic [15:0] r_io;
    logic        r_valid;
    logic        w_commit;
    logic        w_rd;
    action_t     w_act;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .i_row       (bus.row_in),
        .o_col       (w_col),
        .o_scan_done (w_scan_done),
        .o_hit       (w_hit),
        .o_code      (w_code)
    );

    // Debounce state, press counter, release counter and latched code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rel   <= '0;
            r_code  <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rel   <= w_rel_nx;
            r_code  <= w_code_nx;
        end
    end

    // Next-state logic; decisions are taken only on scan boundaries
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rel_nx   = r_rel;
        w_code_nx  = r_code;
        w_fire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_scan_done && w_hit) begin
                    w_code_nx = w_code;
                    if (DEBOUNCE_SCANS == 1) begin
                        w_state_nx = HELD;
                        w_rel_nx   = '0;
                        w_fire     = 1'b1;
                    end else begin
                        w_state_nx = PRESS_DB;
                        w_cnt_nx   = c_ONE;
                    end
                end
            end
            PRESS_DB: begin
                if (w_scan_done) begin
                    if (w_hit && (w_code == r_code)) begin
                        if ((r_cnt + c_ONE) == c_DB) begin
                            w_state_nx = HELD;
                            w_rel_nx   = '0;
                            w_fire     = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + c_ONE;
                        end
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            HELD: begin
                // Any hit, even a different key, restarts the release count
                if (w_scan_done) begin
                    if (w_hit) begin
                        w_rel_nx = '0;
                    end else if ((r_rel + c_ONE) == c_DB) begin
                        w_state_nx = IDLE;
                        w_rel_nx   = '0;
                    end else begin
                        w_rel_nx = r_rel + c_ONE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // The accepting scan_done still presents the debounced code
    assign w_act    = code_to_action(w_code);
    assign w_commit = w_fire && (w_act == COMMIT);
    assign w_rd     = bus.IORead_signal && r_valid;

    // Entry register: shift in digits, clear on '*' or after a commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= 16'd0;
        end else if (w_fire) begin
            case (w_act)
                DIGIT:   r_entry <= {r_entry[11:0], code_to_nibble(w_code)};
                default: r_entry <= 16'd0;
            endcase
        end
    end

    // IO word and valid flag; a commit beats a coincident read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_io    <= 16'd0;
            r_valid <= 1'b0;
        end else begin
            if (w_commit) begin
                r_io <= r_entry;
            end
            r_valid <= w_commit | (r_valid & ~w_rd);
        end
    end

`ifdef KEYPAD_OVERRUN_EN
    logic r_overrun;

    // Sticky flag for a commit over an unread word; set beats a coincident read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= (w_commit & r_valid) | (r_overrun & ~w_rd);
        end
    end

    assign bus.overrun = r_overrun;
`endif

    assign bus.col_out      = w_col;
    assign bus.io_read_data = r_io;
    assign bus.data_valid   = r_valid;
    assign bus.entry_data   = r_entry;
    assign bus.key_pressed  = (r_state == HELD);

endmodule : keypad_reader
`default_nettype wire

// File: tb/tb_keypad_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_reader
// Description : Directed self-checking bench for keypad_reader with
//               SCAN_DIV=4, DEBOUNCE_SCANS=2. A behavioural 4x4 matrix turns
//               the set of held keys into row levels from the column drive.
//               Checks the overrun flag when KEYPAD_OVERRUN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_reader;

    localparam int c_SCAN = 16;     // cycles per full scan (4 * SCAN_DIV)

    // {row,col} codes of the keys used below
    localparam logic [3:0] K1 = 4'h0, K2 = 4'h1, K3 = 4'h2, KA = 4'h3;
    localparam logic [3:0] K4 = 4'h4, K5 = 4'h5, K6 = 4'h6;
    localparam logic [3:0] K7 = 4'h8, K9 = 4'hA, K0 = 4'hD;
    localparam logic [3:0] KSTAR = 4'hC, KHASH = 4'hE;

    logic        clk;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  w_rows;
    int          n_checks;
    int          n_pass;

    keypad_if bus();

    keypad_reader #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven
    always_comb begin
        w_rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!bus.col_out[c] && keys[r*4 + c]) begin
                    w_rows[r] = 1'b0;
                end
            end
        end
    end
    assign bus.row_in = w_rows;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int hold_scans, input int rel_scans);
        keys = 16'd1 << code;
        tick(hold_scans * c_SCAN);
        keys = 16'd0;
        tick(rel_scans * c_SCAN);
    endtask

    // Land in the first cycle of column 0, which is the scan_done cycle
    task automatic sync_scan_start();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (bus.col_out == 4'b0111) found = 1'b1;
        end
        if (found) begin
            found = 1'b0;
            for (int i = 0; i < 8 && !found; i++) begin
                tick(1);
                if (bus.col_out == 4'b1110) found = 1'b1;
            end
        end
        check_eq("scan_sync", {15'd0, found}, 16'd1);
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        keys              = 16'd0;
        bus.IORead_signal = 1'b0;
        rst               = 1'b0;

        // ---- 1. reset mid-scan and column walk ----
        tick(3);
        @(negedge clk) rst = 1'b1;
        tick(7);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_col",   {12'd0, bus.col_out}, 16'h000E);
        check_eq("rst_entry", bus.entry_data, 16'h0000);
        check_eq("rst_io",    bus.io_read_data, 16'h0000);
        check_eq("rst_valid", {15'd0, bus.data_valid}, 16'd0);
        check_eq("rst_key",   {15'd0, bus.key_pressed}, 16'd0);
`ifdef KEYPAD_OVERRUN_EN
        check_eq("rst_ovr",   {15'd0, bus.overrun}, 16'd0);
`endif
        @(negedge clk) rst = 1'b1;
        tick(2);
        check_eq("walk_c0", {12'd0, bus.col_out}, 16'h000E);
        tick(4);
        check_eq("walk_c1", {12'd0, bus.col_out}, 16'h000D);
        tick(4);
        check_eq("walk_c2", {12'd0, bus.col_out}, 16'h000B);
        tick(4);
        check_eq("walk_c3", {12'd0, bus.col_out}, 16'h0007);
        tick(4);
        check_eq("walk_wrap", {12'd0, bus.col_out}, 16'h000E);

        // ---- 2. digit entry with wrap ----
        press(K1, 3, 3);
        check_eq("digit_1", bus.entry_data, 16'h0001);
        press(K2, 3, 3);
        press(KA, 3, 3);
        press(K0, 3, 3);
        check_eq("digits_12A0", bus.entry_data, 16'h12A0);
        check_eq("digits_valid", {15'd0, bus.data_valid}, 16'd0);
        press(K5, 3, 3);
        check_eq("digits_wrap", bus.entry_data, 16'h2A05);

        // ---- 3. commit and read ----
        press(KSTAR, 3, 3);
        check_eq("star_clear", bus.entry_data, 16'h0000);
        press(K3, 3, 3);
        press(K7, 3, 3);
        check_eq("entry_0037", bus.entry_data, 16'h0037);
        press(KHASH, 3, 3);
        check_eq("commit_valid", {15'd0, bus.data_valid}, 16'd1);
        check_eq("commit_io",    bus.io_read_data, 16'h0037);
        check_eq("commit_entry", bus.entry_data, 16'h0000);
        bus.IORead_signal = 1'b1;
        tick(1);
        bus.IORead_signal = 1'b0;
        check_eq("read_valid", {15'd0, bus.data_valid}, 16'd0);
        check_eq("read_io",    bus.io_read_data, 16'h0037);
        bus.IORead_signal = 1'b1;
        tick(1);
        bus.IORead_signal = 1'b0;
        tick(1);
        check_eq("idle_read_valid", {15'd0, bus.data_valid}, 16'd0);
        check_eq("idle_read_io",    bus.io_read_data, 16'h0037);

        // ---- 4. bounce rejection ----
        press(K9, 3, 3);
        check_eq("entry_0009", bus.entry_data, 16'h0009);
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? (16'd1 << K5) : 16'd0;
            tick(c_SCAN);
        end
        keys = 16'd0;
        tick(3 * c_SCAN);
        check_eq("bounce_5", bus.entry_data, 16'h0009);
        keys = (16'd1 << K5) | (16'd1 << K6);
        tick(5 * c_SCAN);
        keys = 16'd0;
        tick(3 * c_SCAN);
        check_eq("ghost_56", bus.entry_data, 16'h0009);
        keys = 16'd1 << K4;
        tick(5 * c_SCAN);
        check_eq("held_key", {15'd0, bus.key_pressed}, 16'd1);
        tick(15 * c_SCAN);
        keys = 16'd0;
        tick(3 * c_SCAN);
        check_eq("no_repeat", bus.entry_data, 16'h0094);
        check_eq("released_key", {15'd0, bus.key_pressed}, 16'd0);

        // ---- 5. clear and commit/read collision ----
        press(KSTAR, 3, 3);
        press(K9, 3, 3);
        press(K9, 3, 3);
        check_eq("entry_0099", bus.entry_data, 16'h0099);
        press(KSTAR, 3, 3);
        check_eq("star_0099", bus.entry_data, 16'h0000);
        press(K4, 3, 3);
        check_eq("entry_0004", bus.entry_data, 16'h0004);
        sync_scan_start();
        keys = 16'd1 << KHASH;
        sync_scan_start();              // scan_done of first '#' scan
        sync_scan_start();              // scan_done of second '#' scan: accept
        check_eq("pre_commit_valid", {15'd0, bus.data_valid}, 16'd0);
        check_eq("pre_commit_entry", bus.entry_data, 16'h0004);
        bus.IORead_signal = 1'b1;
        tick(1);
        bus.IORead_signal = 1'b0;
        check_eq("coll_valid", {15'd0, bus.data_valid}, 16'd1);
        check_eq("coll_io",    bus.io_read_data, 16'h0004);
        check_eq("coll_entry", bus.entry_data, 16'h0000);
`ifdef KEYPAD_OVERRUN_EN
        check_eq("coll_ovr",   {15'd0, bus.overrun}, 16'd0);
`endif
        tick(1);
        check_eq("coll_valid_hold", {15'd0, bus.data_valid}, 16'd1);
        keys = 16'd0;
        tick(3 * c_SCAN);

        // ---- 6. commit over an unread word ----
        press(K7, 3, 3);
        press(KHASH, 3, 3);
        check_eq("ovw_io",    bus.io_read_data, 16'h0007);
        check_eq("ovw_valid", {15'd0, bus.data_valid}, 16'd1);
`ifdef KEYPAD_OVERRUN_EN
        check_eq("ovr_set",   {15'd0, bus.overrun}, 16'd1);
`endif
        bus.IORead_signal = 1'b1;
        tick(1);
        bus.IORead_signal = 1'b0;
        check_eq("ovw_read_valid", {15'd0, bus.data_valid}, 16'd0);
        check_eq("ovw_read_io",    bus.io_read_data, 16'h0007);
`ifdef KEYPAD_OVERRUN_EN
        check_eq("ovr_clear", {15'd0, bus.overrun}, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_keypad_reader
`default_nettype wire
